instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the core's instruction decoder: accepts decoded RISC-V RV32I fields plus a format tag and produces packed 32-bit instruction words.
- Emits words through a registered valid/ready stream tagged with a sequential word address; used by the program loader and benches to build instruction-memory images.
- A small run FSM brackets each program load: start, stream, drain, done pulse.

Parameters:
- ADDR_W, 10, width of the word-address counter (instruction memory depth = 2^ADDR_W words)
- BASE_ADDR, 0, word address loaded on start

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a load run, ignored unless FSM is IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_last  in  1  marks final bundle of the run
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal
- opcode  in  7  opcode field
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field, R only
- rd, rs1, rs2  in  5 each  register selects
- imm  in  32  full signed immediate (U: full value, low 12 bits expected zero)
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  packed instruction
- out_addr  out  ADDR_W  word address of out_instr
- out_err  out  1  this word was flagged (illegal fmt or immediate out of range)
- err_sticky  out  1  any flagged word since start
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at run end

Behaviour:
- Clock is clk; reset is synchronous, active-low, named rst_n. On reset: state IDLE, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_sticky=0, busy=0, done=0, in_ready=0.
- FSM states:
  - IDLE: start -> RUN; load addr counter to BASE_ADDR; clear err_sticky.
  - RUN: an accepted bundle with in_last=1 -> DRAIN.
  - DRAIN: output register empty, or its word accepted this cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready). Bundles are accepted only on in_valid && in_ready.
- Latency: 1 cycle. A bundle accepted at edge N appears on out_* at N. Full throughput of one word/cycle while out_ready stays high.
- Address: out_addr takes the counter value at acceptance; counter increments per accept and wraps modulo 2^ADDR_W without error.
- Output stability: out_* are held while out_valid && !out_ready.
- Packing:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Illegal fmt: emit 0x00000013 (NOP) with out_err=1.
- err_sticky sets on any word emitted with out_err=1; it clears only on reset or start.
- start while busy: ignored. in_valid outside RUN: not accepted.
- Reset mid-run: the pending word is dropped, the FSM returns to IDLE, and no done pulse is issued.

Optional Feature:
- IMM_RANGE_CHECK_EN
  - Defined: out_err=1 if the immediate does not fit its format:
    - I/S: signed 12-bit
    - B: signed 13-bit and even
    - J: signed 21-bit and even
    - U: imm[11:0]!=0
  - In all cases the word is still emitted with the immediate truncated.
  - Undefined: no range checking; truncate silently; out_err reflects illegal fmt only.

Decomposition:
- Shared package rv_isa_pkg holds:
  - format enum (FMT_R..FMT_J)
  - opcode constants: OP_REG=0110011, OP_IMM=0010011, OP_LUI=0110111, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111
  - NOP_WORD
  - FSM state typedef
- One combinational sub-module, instr_pack, maps (fmt, fields, imm) to (word, err). The top level holds the FSM, address counter and output register.

Test Plan:
- start; I fmt opcode=0010011 rd=1 rs1=0 f3=0 imm=5, in_last=1 -> out_instr=0x00500093, out_addr=0, out_err=0; done pulses 1 cycle after accept.
- Back-to-back stream with out_ready=1:
  - R add x3,x1,x2 -> 0x002081B3 @addr 0
  - S sw x2,8(x1) -> 0x0020A423 @addr 1
  - B beq x1,x2,imm=-4 -> 0xFE208EE3 @addr 2
  - one word per cycle.
- U lui x5 imm=0x12345000 -> 0x123452B7; J jal x1 imm=8 -> 0x008000EF; out_ready held low 3 cycles -> in_ready=0 and out_* stable throughout.
- fmt=7 -> out_instr=0x00000013, out_err=1, err_sticky=1 until next start. With IMM_RANGE_CHECK_EN: B imm=3 -> out_err=1; I imm=2048 -> out_err=1.
- ADDR_W=2: 5 words -> addresses 0,1,2,3,0. Reset asserted during DRAIN -> out_valid=0 next cycle, state IDLE, no done pulse.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding definitions: instruction formats, opcodes, the canonical
// NOP and the load-run FSM states used by instr_encoder.
package rv_isa_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // addi x0,x0,0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // True when v, read as two's complement, survives truncation to w bits.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
      logic [31:0] hi;
      hi = 32'($signed(v) >>> (w - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: (fmt, fields, imm) -> (word, err).
// Immediate range checking is compiled in only when IMM_RANGE_CHECK_EN is defined.
module instr_pack
   import rv_isa_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        err
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      word = NOP_WORD;
      err  = 1'b0;
      case (fmt)
         FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
            err = !fits_signed(imm, 12);
`endif
         end
         FMT_S: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef IMM_RANGE_CHECK_EN
            err = !fits_signed(imm, 12);
`endif
         end
         FMT_B: begin
            word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef IMM_RANGE_CHECK_EN
            err = !fits_signed(imm, 13) || imm[0];
`endif
         end
         FMT_U: begin
            word = {imm[31:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
            err = (imm[11:0] != 12'h000);
`endif
         end
         FMT_J: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
            err = !fits_signed(imm, 21) || imm[0];
`endif
         end
         default: begin
            word = NOP_WORD;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: run FSM, word-address counter and registered
// valid/ready output stage around instr_pack. Optional macro: IMM_RANGE_CHECK_EN.
module instr_encoder
   import rv_isa_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic              err_sticky,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t            state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [31:0]       pack_word;
   logic              pack_err;
   logic              accept;

   instr_pack u_pack (
      .fmt    (fmt),
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .imm    (imm),
      .word   (pack_word),
      .err    (pack_err)
   );

   assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         addr_cnt   <= BASE;
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_addr   <= BASE;
         out_err    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         // An accept can coincide with the consumer taking the previous word.
         if (accept) begin
            out_valid <= 1'b1;
            out_instr <= pack_word;
            out_err   <= pack_err;
            out_addr  <= addr_cnt;
            addr_cnt  <= addr_cnt + 1'b1;
            if (pack_err) begin
               err_sticky <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_RUN;
                  addr_cnt   <= BASE;
                  err_sticky <= 1'b0;
               end
            end
            ST_RUN: begin
               if (accept && in_last) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!out_valid || out_ready) begin
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
